// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed 7-segment scan driver.
// Holds active-low glyphs ([6:0] = g,f,e,d,c,b,a), the all-off pattern,
// the anode-off pattern and the scan FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] AN_OFF   = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: load-side and display-side signals of the scan driver.
//   bcd_in[15:0], dp_in[3:0], load : new digit data and its capture strobe
//   pend       : uncommitted data waiting for the next frame boundary
//   seg[7:0]   : active-low segments, [7] = dp
//   an[3:0]    : active-low one-hot anode enables
//   frame_done : one-cycle pulse after each frame commit point
// master = data source / display observer, slave = seg_scan.
interface seg_scan_if;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        pend;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  modport master (output bcd_in, dp_in, load,
                  input  pend, seg, an, frame_done);
  modport slave  (input  bcd_in, dp_in, load,
                  output pend, seg, an, frame_done);
endinterface

// File: rtl/seg_decode.sv
// seg_decode: combinational BCD + decimal point to active-low segment pattern.
//   bcd[3:0] : digit value; 10..15 render as a dash
//   dp       : decimal point, active-high in, active-low out on seg_c[7]
//   seg_c    : {~dp, g,f,e,d,c,b,a}
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg_c
);

  logic [6:0] glyph;

  // Glyph lookup; anything outside 0..9 is shown as a dash.
  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

  assign seg_c = {~dp, glyph};

endmodule

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment driver with double buffering.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : seg_scan_if.slave (bcd_in/dp_in/load in; pend/seg/an/frame_done out)
// Each slot is DIV cycles: BLANK_CYC with all anodes off, then the digit.
// Pending data is copied to the active buffer only at the end of digit 3's
// slot, so a frame never mixes old and new digits.
// Optional: define SEG_LZB_EN for leading-zero blanking of digits 3..1.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      pend_bcd;
  logic [3:0]       pend_dp;
  logic [15:0]      act_bcd;
  logic [3:0]       act_dp;
  logic             pend_q;
  logic [7:0]       seg_q;
  logic [3:0]       an_q;
  logic             frame_done_q;

  logic [3:0]       digit_c;
  logic             dp_c;
  logic [7:0]       dec_seg_c;
  logic             blank_c;
  logic             slot_end_c;
  logic             blank_end_c;
  logic             commit_c;

  assign slot_end_c  = (cnt == CNT_LAST);
  assign blank_end_c = (cnt == CNT_BLANK_LAST);
  assign commit_c    = (state == ST_SHOW) && slot_end_c && (idx == 2'd3);

  // Digit currently being scanned, taken from the active buffer.
  assign digit_c = act_bcd[{idx, 2'b00} +: 4];
  assign dp_c    = act_dp[idx];

  seg_decode u_decode (
    .bcd   (digit_c),
    .dp    (dp_c),
    .seg_c (dec_seg_c)
  );

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every more significant digit are 0.
  logic lz3_c, lz2_c, lz1_c;
  assign lz3_c   = (act_bcd[15:12] == 4'd0);
  assign lz2_c   = lz3_c && (act_bcd[11:8] == 4'd0);
  assign lz1_c   = lz2_c && (act_bcd[7:4] == 4'd0);
  assign blank_c = (idx == 2'd3) ? lz3_c :
                   (idx == 2'd2) ? lz2_c :
                   (idx == 2'd1) ? lz1_c : 1'b0;
`else
  assign blank_c = 1'b0;
`endif

  // Scan FSM, registered display outputs and buffer management.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= 2'd0;
      pend_bcd     <= 16'd0;
      pend_dp      <= 4'd0;
      act_bcd      <= 16'd0;
      act_dp       <= 4'd0;
      pend_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt <= slot_end_c ? '0 : cnt + CNT_W'(1);

      case (state)
        ST_BLANK: if (blank_end_c) state <= ST_SHOW;
        ST_SHOW: begin
          if (slot_end_c) begin
            state <= ST_BLANK;
            idx   <= idx + 2'd1;
          end
        end
      endcase

      // Outputs follow the current state, one cycle behind the transition.
      if (state == ST_SHOW) begin
        an_q  <= ~(4'b0001 << idx);
        seg_q <= blank_c ? SEG_OFF : dec_seg_c;
      end else begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
      end

      frame_done_q <= commit_c;

      // A load coinciding with the commit bypasses the pending buffer.
      if (commit_c) begin
        if (bus.load) begin
          act_bcd <= bus.bcd_in;
          act_dp  <= bus.dp_in;
        end else if (pend_q) begin
          act_bcd <= pend_bcd;
          act_dp  <= pend_dp;
        end
        pend_q <= 1'b0;
      end else if (bus.load) begin
        pend_bcd <= bus.bcd_in;
        pend_dp  <= bus.dp_in;
        pend_q   <= 1'b1;
      end
    end
  end

  assign bus.pend       = pend_q;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with DIV=8, BLANK_CYC=2.
// Expected digit slots are queued when data is expected on screen; a
// monitor measures each anode-low run and pops/compares at its end.
module tb_seg_scan;

  localparam int unsigned DIV       = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned SHOW_CYC  = DIV - BLANK_CYC;
  localparam int unsigned FRAME     = 4 * DIV;

  typedef struct {
    int         idx;
    logic [7:0] seg;
  } slot_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  slot_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference glyphs, active-low {dp, g..a}.
  function automatic logic [7:0] exp_seg(input logic [15:0] b, input logic [3:0] d, input int i);
    logic [15:0] sh;
    logic [6:0]  g;
    logic        blank;
    sh = b >> (4 * i);
    case (sh[3:0])
      4'd0: g = 7'h40;
      4'd1: g = 7'h79;
      4'd2: g = 7'h24;
      4'd3: g = 7'h30;
      4'd4: g = 7'h19;
      4'd5: g = 7'h12;
      4'd6: g = 7'h02;
      4'd7: g = 7'h78;
      4'd8: g = 7'h00;
      4'd9: g = 7'h10;
      default: g = 7'h3F;
    endcase
    blank = 1'b0;
`ifdef SEG_LZB_EN
    if (i > 0) begin
      blank = 1'b1;
      for (int j = i; j < 4; j++) begin
        sh = b >> (4 * j);
        if (sh[3:0] != 4'd0) blank = 1'b0;
      end
    end
`endif
    return blank ? 8'hFF : {~d[i], g};
  endfunction

  task automatic push_frame(input logic [15:0] b, input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      slot_exp_t e;
      e.idx = i;
      e.seg = exp_seg(b, d, i);
      sb.push_back(e);
    end
  endtask

  // Slot monitor: measures each anode-low run.
  int         run_len = 0;
  logic [3:0] run_an;
  logic [7:0] run_seg;
  bit         run_tracked;
  bit         run_glitch;
  slot_exp_t  mon_e;
  logic [3:0] mon_exp_an;

  always @(negedge clk) begin
    if (bus.an != 4'hF) begin
      if (run_len == 0) begin
        run_an      = bus.an;
        run_seg     = bus.seg;
        run_tracked = (sb.size() != 0);
        run_glitch  = 1'b0;
      end else if (bus.an != run_an || bus.seg != run_seg) begin
        run_glitch = 1'b1;
      end
      run_len++;
    end else if (run_len != 0) begin
      if (run_tracked && sb.size() != 0) begin
        mon_e      = sb.pop_front();
        mon_exp_an = ~(4'b0001 << mon_e.idx);
        check_eq("slot_an", 32'(run_an), 32'(mon_exp_an));
        check_eq("slot_seg", 32'(run_seg), 32'(mon_e.seg));
        check_eq("slot_len", 32'(run_len), 32'(SHOW_CYC));
        check_eq("slot_stable", 32'(run_glitch), 32'd0);
      end
      run_len = 0;
    end
  end

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    @(negedge clk);
    bus.bcd_in = b;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    check_eq("pend_after_load", 32'(bus.pend), 32'd1);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 3 * FRAME);
    check_eq("frame_done_seen", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_release();
    repeat (2) @(negedge clk);
    check_eq("an_blank_after_rst", 32'(bus.an), 32'hF);
    @(negedge clk);
    check_eq("first_anode", 32'(bus.an), 32'hE);
  endtask

  initial begin
    bus.bcd_in = 16'd0;
    bus.dp_in  = 4'd0;
    bus.load   = 1'b0;

    // Reset values and first anode timing.
    repeat (3) @(negedge clk);
    check_eq("rst_an", 32'(bus.an), 32'hF);
    check_eq("rst_seg", 32'(bus.seg), 32'hFF);
    check_eq("rst_pend", 32'(bus.pend), 32'd0);
    check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000);
    check_reset_release();
    wait_drain();

    // Normal digits with a decimal point on digit 2.
    do_load(16'h1234, 4'b0100);
    wait_frame_done();
    check_eq("pend_cleared", 32'(bus.pend), 32'd0);
    push_frame(16'h1234, 4'b0100);
    wait_drain();

    // Non-BCD nibbles render as dashes.
    do_load(16'hA0F5, 4'b0000);
    wait_frame_done();
    push_frame(16'hA0F5, 4'b0000);
    wait_drain();

    // Last load before the commit wins.
    do_load(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_frame_done();
    check_eq("pend_double_cleared", 32'(bus.pend), 32'd0);
    push_frame(16'h2222, 4'b0000);
    wait_drain();

    // Leading-zero patterns.
    do_load(16'h0040, 4'b1111);
    wait_frame_done();
    push_frame(16'h0040, 4'b1111);
    wait_drain();

    do_load(16'h0000, 4'b0000);
    wait_frame_done();
    push_frame(16'h0000, 4'b0000);
    wait_drain();

    // Load exactly in the commit cycle goes straight to the display.
    wait_frame_done();
    repeat (FRAME - 1) @(negedge clk);
    check_eq("fd_before_commit", 32'(bus.frame_done), 32'd0);
    bus.bcd_in = 16'h9876;
    bus.dp_in  = 4'b1001;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    check_eq("fd_commit_load", 32'(bus.frame_done), 32'd1);
    check_eq("pend_commit_load", 32'(bus.pend), 32'd0);
    push_frame(16'h9876, 4'b1001);
    @(negedge clk);
    check_eq("fd_single_pulse", 32'(bus.frame_done), 32'd0);
    check_eq("pend_commit_load_hold", 32'(bus.pend), 32'd0);
    wait_drain();

    // Mid-frame reset drops both buffers.
    do_load(16'h5555, 4'b1111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_an", 32'(bus.an), 32'hF);
    check_eq("midrst_seg", 32'(bus.seg), 32'hFF);
    check_eq("midrst_pend", 32'(bus.pend), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000);
    check_reset_release();
    wait_drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
